// File: rtl/voice_allocator.sv
// Polyphonic key-to-voice scheduler: a key edge reaches gate/phase_inc two edges later, one event per cycle, no backpressure.
// Build option VOICE_STEAL_EN: steal the oldest ACTIVE voice instead of pulsing drop_out when all voices play.
module voice_allocator #(
  parameter int NUM_KEYS             = 7,
  parameter int NUM_VOICES           = 4,
  parameter int RELEASE_CYCLES       = 4800,
  parameter int AGE_BITS             = 16,
  parameter int SYNTH_PHASE_ACC_BITS = 24
) (
  input  logic                                       clk_in,
  input  logic                                       rst_n_in,
  input  logic [NUM_KEYS-1:0]                        key_in,
  output logic [NUM_VOICES*SYNTH_PHASE_ACC_BITS-1:0] voice_phase_inc_out,
  output logic [NUM_VOICES-1:0]                      voice_gate_out,
  output logic [NUM_VOICES-1:0]                      voice_trig_out,
  output logic [NUM_VOICES-1:0]                      voice_busy_out,
  output logic                                       drop_out
);
  localparam int W  = SYNTH_PHASE_ACC_BITS;
  localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int RW = $clog2(RELEASE_CYCLES + 1);
  localparam logic [RW-1:0]       REL_LOAD = RW'(RELEASE_CYCLES - 1);
  localparam logic [AGE_BITS-1:0] AGE_MAX  = '1;

  typedef enum logic [1:0] {IDLE, ACTIVE, RELEASE} vstate_t;

  function automatic logic [W-1:0] key_inc(input logic [KW-1:0] k);
    case (int'(k))
      0:       key_inc = W'(24'h0D465);
      1:       key_inc = W'(24'h0C87A);
      2:       key_inc = W'(24'h0BD3A);
      3:       key_inc = W'(24'h0B29A);
      4:       key_inc = W'(24'h0A894);
      5:       key_inc = W'(24'h09F1E);
      6:       key_inc = W'(24'h09630);
      default: key_inc = '0;
    endcase
  endfunction

  vstate_t             state_q [NUM_VOICES];
  vstate_t             state_d [NUM_VOICES];
  logic [KW-1:0]       vkey_q  [NUM_VOICES];
  logic [KW-1:0]       vkey_d  [NUM_VOICES];
  logic [W-1:0]        inc_q   [NUM_VOICES];
  logic [W-1:0]        inc_d   [NUM_VOICES];
  logic [AGE_BITS-1:0] age_q   [NUM_VOICES];
  logic [AGE_BITS-1:0] age_d   [NUM_VOICES];
  logic [RW-1:0]       rel_q   [NUM_VOICES];
  logic [RW-1:0]       rel_d   [NUM_VOICES];

  logic [NUM_KEYS-1:0]   key_q, pend_on_q, pend_off_q, pend_on_d, pend_off_d;
  logic [NUM_KEYS-1:0]   rise, fall, svc_mask, svc_on, svc_off, cancel;
  logic [KW-1:0]         skey;
  logic                  do_on, do_off;
  logic [NUM_VOICES-1:0] off_hit, alloc, trig_q;
  logic [VW-1:0]         retrig_idx, idle_idx, rel_idx;
  logic                  have_retrig, have_idle, have_rel;
  logic                  drop_d, drop_q;
`ifdef VOICE_STEAL_EN
  logic [VW-1:0]         steal_idx;
  logic [AGE_BITS-1:0]   steal_age;
`endif

  always_comb begin
    rise     = key_in & ~key_q;
    fall     = ~key_in & key_q;
    do_off   = |pend_off_q;
    do_on    = ~do_off & (|pend_on_q);
    skey     = '0;
    svc_mask = '0;
    // Descending scan so the lowest pending index is the last one written.
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (do_off ? pend_off_q[k] : pend_on_q[k]) skey = KW'(k);
    end
    if (do_off || do_on) svc_mask[skey] = 1'b1;
    svc_on  = do_on  ? svc_mask : '0;
    svc_off = do_off ? svc_mask : '0;
    // A press that releases before being serviced never sounds.
    cancel     = fall & pend_on_q & ~svc_on;
    pend_on_d  = ((pend_on_q & ~svc_on) | rise) & ~cancel;
    pend_off_d = ((pend_off_q & ~svc_off) | fall) & ~cancel;

    off_hit     = '0;
    have_retrig = 1'b0;
    have_idle   = 1'b0;
    have_rel    = 1'b0;
    retrig_idx  = '0;
    idle_idx    = '0;
    rel_idx     = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (do_off && state_q[v] == ACTIVE && vkey_q[v] == skey && off_hit == '0)
        off_hit[v] = 1'b1;
      if (!have_retrig && state_q[v] == RELEASE && vkey_q[v] == skey) begin
        have_retrig = 1'b1;
        retrig_idx  = VW'(v);
      end
      if (!have_idle && state_q[v] == IDLE) begin
        have_idle = 1'b1;
        idle_idx  = VW'(v);
      end
      if (!have_rel && state_q[v] == RELEASE) begin
        have_rel = 1'b1;
        rel_idx  = VW'(v);
      end
    end
`ifdef VOICE_STEAL_EN
    steal_idx = '0;
    steal_age = age_q[0];
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (age_q[v] > steal_age) begin
        steal_age = age_q[v];
        steal_idx = VW'(v);
      end
    end
`endif

    alloc  = '0;
    drop_d = 1'b0;
    if (do_on) begin
      if (have_retrig)    alloc[retrig_idx] = 1'b1;
      else if (have_idle) alloc[idle_idx]   = 1'b1;
      else if (have_rel)  alloc[rel_idx]    = 1'b1;
      else begin
`ifdef VOICE_STEAL_EN
        alloc[steal_idx] = 1'b1;
`else
        drop_d = 1'b1;
`endif
      end
    end

    for (int v = 0; v < NUM_VOICES; v++) begin
      state_d[v] = state_q[v];
      vkey_d[v]  = vkey_q[v];
      inc_d[v]   = inc_q[v];
      rel_d[v]   = rel_q[v];
      age_d[v]   = (state_q[v] != IDLE && age_q[v] != AGE_MAX) ? age_q[v] + 1'b1 : age_q[v];
      if (alloc[v]) begin
        state_d[v] = ACTIVE;
        vkey_d[v]  = skey;
        inc_d[v]   = key_inc(skey);
        age_d[v]   = '0;
      end else if (off_hit[v]) begin
        state_d[v] = RELEASE;
        rel_d[v]   = REL_LOAD;
      end else if (state_q[v] == RELEASE) begin
        if (rel_q[v] == '0) begin
          state_d[v] = IDLE;
          inc_d[v]   = '0;
        end else begin
          rel_d[v] = rel_q[v] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      key_q      <= '0;
      pend_on_q  <= '0;
      pend_off_q <= '0;
      trig_q     <= '0;
      drop_q     <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        state_q[v] <= IDLE;
        vkey_q[v]  <= '0;
        inc_q[v]   <= '0;
        age_q[v]   <= '0;
        rel_q[v]   <= '0;
      end
    end else begin
      key_q      <= key_in;
      pend_on_q  <= pend_on_d;
      pend_off_q <= pend_off_d;
      trig_q     <= alloc;
      drop_q     <= drop_d;
      for (int v = 0; v < NUM_VOICES; v++) begin
        state_q[v] <= state_d[v];
        vkey_q[v]  <= vkey_d[v];
        inc_q[v]   <= inc_d[v];
        age_q[v]   <= age_d[v];
        rel_q[v]   <= rel_d[v];
      end
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_out
    assign voice_phase_inc_out[v*W +: W] = inc_q[v];
    assign voice_gate_out[v]             = (state_q[v] == ACTIVE);
    assign voice_busy_out[v]             = (state_q[v] != IDLE);
  end
  assign voice_trig_out = trig_q;
  assign drop_out       = drop_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: edge latency, release tail, retrigger, glitch cancel, overflow.
module tb_voice_allocator;
  localparam int NK = 7;
  localparam int NV = 4;
  localparam int W  = 24;

  logic          clk;
  logic          rst_n;
  logic [NK-1:0] key;
  logic [NV*W-1:0] inc_bus;
  logic [NV-1:0] gate, trig, busy;
  logic          drop;

  int total = 0;
  int bad   = 0;

  voice_allocator dut (
    .clk_in             (clk),
    .rst_n_in           (rst_n),
    .key_in             (key),
    .voice_phase_inc_out(inc_bus),
    .voice_gate_out     (gate),
    .voice_trig_out     (trig),
    .voice_busy_out     (busy),
    .drop_out           (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] vinc(input int v);
    logic [NV*W-1:0] bus;
    bus = inc_bus;
    return 32'(bus[v*W +: W]);
  endfunction

  task automatic do_reset();
    key   = '0;
    rst_n = 1'b0;
    #1;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b1;
    key   = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_gate", 32'(gate), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_trig", 32'(trig), 32'h0);
    chk("rst_drop", 32'(drop), 32'h0);
    chk("rst_inc_bus", 32'(|inc_bus), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    tick();

    // single key 6
    key = 7'b1000000;
    tick();
    chk("single_gate_k", 32'(gate), 32'h0);
    tick();
    chk("single_gate_k1", 32'(gate), 32'h1);
    chk("single_inc_k1", vinc(0), 32'h09630);
    chk("single_trig_k1", 32'(trig), 32'h1);
    chk("single_busy_k1", 32'(busy), 32'h1);
    tick();
    chk("single_trig_k2", 32'(trig), 32'h0);
    chk("single_gate_k2", 32'(gate), 32'h1);
    key = '0;
    tick();
    chk("off_gate_j", 32'(gate), 32'h1);
    tick();
    chk("off_gate_j1", 32'(gate), 32'h0);
    chk("off_busy_j1", 32'(busy), 32'h1);
    chk("off_inc_hold", vinc(0), 32'h09630);
    repeat (4799) tick();
    chk("tail_busy_last", 32'(busy), 32'h1);
    chk("tail_inc_last", vinc(0), 32'h09630);
    tick();
    chk("tail_busy_done", 32'(busy), 32'h0);
    chk("tail_inc_done", vinc(0), 32'h0);

    // reset mid-note with key 6 held
    key = 7'b1000000;
    tick();
    tick();
    chk("mid_gate_before", 32'(gate), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_gate", 32'(gate), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_inc", vinc(0), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("mid_rel_gate_e1", 32'(gate), 32'h0);
    tick();
    chk("mid_rel_gate_e2", 32'(gate), 32'h1);
    chk("mid_rel_trig_e2", 32'(trig), 32'h1);
    chk("mid_rel_inc_e2", vinc(0), 32'h09630);

    // simultaneous press of keys 0 and 2
    do_reset();
    key = 7'b0000101;
    tick();
    tick();
    chk("simul_gate_k1", 32'(gate), 32'h1);
    chk("simul_inc0", vinc(0), 32'h0D465);
    chk("simul_trig_k1", 32'(trig), 32'h1);
    tick();
    chk("simul_gate_k2", 32'(gate), 32'h3);
    chk("simul_inc1", vinc(1), 32'h0BD3A);
    chk("simul_trig_k2", 32'(trig), 32'h2);

    // glitch on key 5 while the key 0 note-off is pending
    key = 7'b0100100;
    tick();
    key = 7'b0000100;
    tick();
    chk("glitch_gate_a", 32'(gate), 32'h2);
    chk("glitch_busy_a", 32'(busy), 32'h3);
    chk("glitch_drop_a", 32'(drop), 32'h0);
    tick();
    chk("glitch_gate_b", 32'(gate), 32'h2);
    chk("glitch_trig_b", 32'(trig), 32'h0);
    chk("glitch_drop_b", 32'(drop), 32'h0);
    tick();
    chk("glitch_busy_c", 32'(busy), 32'h3);

    // retrigger of key 3 during its release tail
    do_reset();
    key = 7'b0001000;
    tick();
    tick();
    chk("retrig_inc_first", vinc(0), 32'h0B29A);
    key = '0;
    tick();
    tick();
    chk("retrig_rel_busy", 32'(busy), 32'h1);
    chk("retrig_rel_gate", 32'(gate), 32'h0);
    repeat (100) tick();
    key = 7'b0001000;
    tick();
    tick();
    chk("retrig_gate", 32'(gate), 32'h1);
    chk("retrig_trig", 32'(trig), 32'h1);
    chk("retrig_busy", 32'(busy), 32'h1);
    chk("retrig_inc", vinc(0), 32'h0B29A);

    // overflow: keys 0..3 on successive cycles, then key 4
    do_reset();
    key = 7'b0000001;
    tick();
    key = 7'b0000011;
    tick();
    key = 7'b0000111;
    tick();
    key = 7'b0001111;
    tick();
    key = 7'b0011111;
    tick();
    chk("ovf_gate_full", 32'(gate), 32'hF);
    chk("ovf_trig_v3", 32'(trig), 32'h8);
    tick();
    chk("ovf_gate_after", 32'(gate), 32'hF);
    chk("ovf_inc1", vinc(1), 32'h0C87A);
    chk("ovf_inc2", vinc(2), 32'h0BD3A);
    chk("ovf_inc3", vinc(3), 32'h0B29A);
`ifdef VOICE_STEAL_EN
    chk("ovf_steal_inc0", vinc(0), 32'h0A894);
    chk("ovf_steal_trig", 32'(trig), 32'h1);
    chk("ovf_steal_drop", 32'(drop), 32'h0);
`else
    chk("ovf_drop_inc0", vinc(0), 32'h0D465);
    chk("ovf_drop_trig", 32'(trig), 32'h0);
    chk("ovf_drop_pulse", 32'(drop), 32'h1);
    tick();
    chk("ovf_drop_clear", 32'(drop), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
